// File: rtl/coord_project_pipe_if.sv
// Handshake and configuration bundle for coord_project_pipe.
// The master side feeds samples, writes intrinsics and accepts results.
// The slave side is the projection block.
interface coord_project_pipe_if #(
    parameter int IN_W  = 32,
    parameter int Z_W   = 16,
    parameter int K_W   = 10,
    parameter int OUT_W = 16
) ();
    logic                    cfg_we;
    logic [1:0]              cfg_addr;
    logic [K_W-1:0]          cfg_wdata;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  x;
    logic signed [IN_W-1:0]  y;
    logic signed [Z_W-1:0]   z;

    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        u;
    logic [OUT_W-1:0]        v;
    logic                    out_zinv;
    logic                    out_clip;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata,
        output in_valid, x, y, z,
        output out_ready,
        input  in_ready, out_valid, u, v, out_zinv, out_clip
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata,
        input  in_valid, x, y, z,
        input  out_ready,
        output in_ready, out_valid, u, v, out_zinv, out_clip
    );
endinterface

// File: rtl/coord_project_pipe.sv
// Pinhole projection of a camera-frame point (x,y,z) to pixel (u,v).
// One sample in flight: multiply by intrinsics, divide by z with a pair of
// bit-serial restoring dividers, scale to display resolution, clip to image.
module coord_project_pipe #(
    parameter int IN_W      = 32,
    parameter int Z_W       = 16,
    parameter int K_W       = 10,
    parameter int OUT_W     = 16,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int SCALE_NUM = 337,
    parameter int SCALE_SH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    coord_project_pipe_if.slave bus
);
    // Quotient magnitude width, signed numerator width, scaled-product width.
    localparam int NW  = IN_W + K_W + 1;
    localparam int PW  = NW + 1;
    localparam int SNW = $clog2(SCALE_NUM + 1) + 1;
    localparam int SW  = PW + SNW;
    localparam int CW  = $clog2(NW);

    localparam logic [K_W-1:0]       FX_DEF = K_W'(437);
    localparam logic [K_W-1:0]       FY_DEF = K_W'(330);
    localparam logic [K_W-1:0]       CX_DEF = K_W'(242);
    localparam logic [K_W-1:0]       CY_DEF = K_W'(145);
    localparam logic signed [SW-1:0] U_MAX  = SW'(IMG_W - 1);
    localparam logic signed [SW-1:0] V_MAX  = SW'(IMG_H - 1);
    localparam logic signed [SW-1:0] SCALE  = SW'(SCALE_NUM);
    localparam logic [CW-1:0]        LAST   = CW'(NW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_POST,
        S_OUT
    } state_t;

    state_t state, state_n;

    // Runtime intrinsics and their per-sample snapshot.
    logic [K_W-1:0] fx, fy, cx, cy;
    logic [K_W-1:0] fx_s, fy_s, cx_s, cy_s;

    logic signed [IN_W-1:0] x_r, y_r;
    logic signed [Z_W-1:0]  z_r;
    logic                   z_le0;

    // Divider state: num holds the dividend and fills with quotient bits.
    logic [NW-1:0]  num_u, num_v;
    logic [Z_W-2:0] rem_u, rem_v;
    logic [Z_W-2:0] dvs;
    logic           neg_u, neg_v;
    logic [CW-1:0]  cnt;

    logic                 post_ph;
    logic                 zinv_r;
    logic signed [SW-1:0] su, sv;

    logic [OUT_W-1:0] u_r, v_r;
    logic             zinv_o, clip_o;

    // Combinational datapath nets.
    logic signed [PW-1:0] nu, nv;
    logic [NW-1:0]        nu_abs, nv_abs;
    logic [Z_W-1:0]       ru_sh, rv_sh;
    logic                 ge_u, ge_v;
    logic [Z_W-2:0]       rem_un, rem_vn;
    logic signed [PW-1:0] qu, qv;
    logic signed [SW-1:0] su_n, sv_n;
    logic [OUT_W-1:0]     u_n, v_n;
    logic                 cu, cv;

    assign z_le0 = z_r[Z_W-1] || (z_r == '0);

    // Projected numerators from the snapshotted intrinsics, plus magnitudes.
    always_comb begin
        nu = $signed({{(PW-K_W){1'b0}}, fx_s}) * $signed({{(PW-IN_W){x_r[IN_W-1]}}, x_r})
           + $signed({{(PW-K_W){1'b0}}, cx_s}) * $signed({{(PW-Z_W){z_r[Z_W-1]}}, z_r});
        nv = $signed({{(PW-K_W){1'b0}}, fy_s}) * $signed({{(PW-IN_W){y_r[IN_W-1]}}, y_r})
           + $signed({{(PW-K_W){1'b0}}, cy_s}) * $signed({{(PW-Z_W){z_r[Z_W-1]}}, z_r});
        nu_abs = nu[PW-1] ? (~nu[NW-1:0] + 1'b1) : nu[NW-1:0];
        nv_abs = nv[PW-1] ? (~nv[NW-1:0] + 1'b1) : nv[NW-1:0];
    end

    // One restoring-division step for each of the two dividers.
    // The remainder stays below the divisor, so the low bits of the
    // difference are exact and the top bit is only needed for the compare.
    always_comb begin
        ru_sh  = {rem_u, num_u[NW-1]};
        rv_sh  = {rem_v, num_v[NW-1]};
        ge_u   = (ru_sh >= {1'b0, dvs});
        ge_v   = (rv_sh >= {1'b0, dvs});
        rem_un = ge_u ? (ru_sh[Z_W-2:0] - dvs) : ru_sh[Z_W-2:0];
        rem_vn = ge_v ? (rv_sh[Z_W-2:0] - dvs) : rv_sh[Z_W-2:0];
    end

    // Signed quotients and fixed-point scale (arithmetic shift floors).
    always_comb begin
        qu   = neg_u ? -$signed({1'b0, num_u}) : $signed({1'b0, num_u});
        qv   = neg_v ? -$signed({1'b0, num_v}) : $signed({1'b0, num_v});
        su_n = (SW'(qu) * SCALE) >>> SCALE_SH;
        sv_n = (SW'(qv) * SCALE) >>> SCALE_SH;
    end

    // Clamp scaled coordinates to the image and flag any saturation.
    always_comb begin
        u_n = su[OUT_W-1:0];
        cu  = 1'b0;
        if (su[SW-1]) begin
            u_n = '0;
            cu  = 1'b1;
        end else if (su > U_MAX) begin
            u_n = OUT_W'(IMG_W - 1);
            cu  = 1'b1;
        end
        v_n = sv[OUT_W-1:0];
        cv  = 1'b0;
        if (sv[SW-1]) begin
            v_n = '0;
            cv  = 1'b1;
        end else if (sv > V_MAX) begin
            v_n = OUT_W'(IMG_H - 1);
            cv  = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state sequencing; POST spends two cycles (scale, then clamp).
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (bus.in_valid) state_n = S_MUL;
            S_MUL:  state_n = z_le0 ? S_POST : S_DIV;
            S_DIV:  if (cnt == LAST) state_n = S_POST;
            S_POST: if (post_ph) state_n = S_OUT;
            S_OUT:  if (bus.out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Intrinsic registers and the per-sample datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fx      <= FX_DEF;
            fy      <= FY_DEF;
            cx      <= CX_DEF;
            cy      <= CY_DEF;
            fx_s    <= '0;
            fy_s    <= '0;
            cx_s    <= '0;
            cy_s    <= '0;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            num_u   <= '0;
            num_v   <= '0;
            rem_u   <= '0;
            rem_v   <= '0;
            dvs     <= '0;
            neg_u   <= 1'b0;
            neg_v   <= 1'b0;
            cnt     <= '0;
            post_ph <= 1'b0;
            zinv_r  <= 1'b0;
            su      <= '0;
            sv      <= '0;
            u_r     <= '0;
            v_r     <= '0;
            zinv_o  <= 1'b0;
            clip_o  <= 1'b0;
        end else begin
            if (bus.cfg_we) begin
                case (bus.cfg_addr)
                    2'd0:    fx <= bus.cfg_wdata;
                    2'd1:    fy <= bus.cfg_wdata;
                    2'd2:    cx <= bus.cfg_wdata;
                    default: cy <= bus.cfg_wdata;
                endcase
            end
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        x_r  <= bus.x;
                        y_r  <= bus.y;
                        z_r  <= bus.z;
                        fx_s <= fx;
                        fy_s <= fy;
                        cx_s <= cx;
                        cy_s <= cy;
                    end
                end
                S_MUL: begin
                    num_u  <= nu_abs;
                    num_v  <= nv_abs;
                    neg_u  <= nu[PW-1];
                    neg_v  <= nv[PW-1];
                    rem_u  <= '0;
                    rem_v  <= '0;
                    dvs    <= z_r[Z_W-2:0];
                    cnt    <= '0;
                    zinv_r <= z_le0;
                end
                S_DIV: begin
                    num_u <= {num_u[NW-2:0], ge_u};
                    num_v <= {num_v[NW-2:0], ge_v};
                    rem_u <= rem_un;
                    rem_v <= rem_vn;
                    cnt   <= cnt + 1'b1;
                end
                S_POST: begin
                    post_ph <= ~post_ph;
                    if (!post_ph) begin
                        su <= zinv_r ? '0 : su_n;
                        sv <= zinv_r ? '0 : sv_n;
                    end else begin
                        u_r    <= u_n;
                        v_r    <= v_n;
                        clip_o <= zinv_r ? 1'b0 : (cu | cv);
                        zinv_o <= zinv_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_OUT);
    assign bus.u         = u_r;
    assign bus.v         = v_r;
    assign bus.out_zinv  = zinv_o;
    assign bus.out_clip  = clip_o;
endmodule

// File: tb/tb_coord_project_pipe.sv
// Directed bench for coord_project_pipe with hand-computed expectations.
module tb_coord_project_pipe;
    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int          checks = 0;
    int          errors = 0;

    coord_project_pipe_if #(.IN_W(32), .Z_W(16), .K_W(10), .OUT_W(16)) bus ();

    coord_project_pipe #(
        .IN_W(32), .Z_W(16), .K_W(10), .OUT_W(16),
        .IMG_W(640), .IMG_H(480), .SCALE_NUM(337), .SCALE_SH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input int xi, input int yi, input int zi);
        @(negedge clk);
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.x        = xi;
        bus.y        = yi;
        bus.z        = 16'(zi);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        acc_cyc      = cyc;
        check("in_ready_busy", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic finish(input string tag, input int eu, input int ev, input int ez,
                          input int ec, input int elat, input int hold);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(elat));
        check({tag, "_u"}, 64'(bus.u), 64'(eu));
        check({tag, "_v"}, 64'(bus.v), 64'(ev));
        check({tag, "_zinv"}, 64'(bus.out_zinv), 64'(ez));
        check({tag, "_clip"}, 64'(bus.out_clip), 64'(ec));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, "_hold_u"}, 64'(bus.u), 64'(eu));
            check({tag, "_hold_v"}, 64'(bus.v), 64'(ev));
            check({tag, "_hold_flags"}, 64'({bus.out_zinv, bus.out_clip}), 64'({ez[0], ec[0]}));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_released_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_released_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [9:0] data);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        @(negedge clk);
        bus.cfg_we    = 1'b0;
    endtask

    initial begin
        logic seen;
        rst           = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = '0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.z         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_u", 64'(bus.u), 64'd0);
        check("rst_v", 64'(bus.v), 64'd0);
        check("rst_flags", 64'({bus.out_zinv, bus.out_clip}), 64'd0);
        rst = 1'b0;

        // T1: default intrinsics, in-range result.
        start(1, 1, 10);
        finish("t1", 375, 234, 0, 0, 46, 0);

        // T2: negative numerator, v floors below zero and clips.
        start(-5, -5, 10);
        finish("t2", 30, 0, 0, 1, 46, 0);

        // Upper clamp on both axes.
        start(100, 100, 10);
        finish("hi", 639, 479, 0, 1, 46, 0);

        // T3: non-positive depth bypasses the divider.
        start(7, 7, 0);
        finish("t3z0", 0, 0, 1, 0, 3, 0);
        start(7, 7, -3);
        finish("t3neg", 0, 0, 1, 0, 3, 0);

        // T4: fx write mid-sample only affects the following sample.
        start(1, 1, 10);
        repeat (3) @(negedge clk);
        cfg_write(2'd0, 10'd500);
        finish("t4busy", 375, 234, 0, 0, 46, 0);
        start(1, 1, 10);
        finish("t4next", 384, 234, 0, 0, 46, 0);

        // cy write lands on the v numerator only.
        cfg_write(2'd3, 10'd0);
        start(1, 1, 10);
        finish("cy0", 384, 43, 0, 0, 46, 0);

        // T5: downstream stall holds the result.
        start(1, 1, 10);
        finish("t5", 384, 43, 0, 0, 46, 5);

        // T6: reset during the divide aborts and restores defaults.
        start(1, 1, 10);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_in_ready_after", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        check("t6_no_out_valid", 64'(seen), 64'd0);
        start(1, 1, 10);
        finish("t6repeat", 375, 234, 0, 0, 46, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
